// File: rtl/hex_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hex_msg_scheduler
// Purpose  : Drives the six-digit HEX bank of the scaler coprocessor board.
//            Shows the selected algorithm code and schedules BUSY / timed
//            DONE / blinking ERROR messages, with registered segment outputs.
// Revision : 1.0 - initial release
// ============================================================================
module hex_msg_scheduler #(
   parameter int HOLD_CYCLES  = 50000000,
   parameter int BLINK_CYCLES = 12500000,
   parameter int CNT_W        = 26
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic [1:0] ALGORITHM,
   input  logic       ALG_LOAD,
   input  logic [1:0] STATUS,
   input  logic       STATUS_LOAD,
   input  logic       ACK,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5,
   output logic [2:0] MODE
);

   // Active-low glyphs, bit0 = segment a ... bit6 = segment g
   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_A     = 7'b0001000;
   localparam logic [6:0] G_B     = 7'b0000011;
   localparam logic [6:0] G_C     = 7'b1000110;
   localparam logic [6:0] G_D     = 7'b0100001;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_N     = 7'b0101011;
   localparam logic [6:0] G_O     = 7'b0100011;
   localparam logic [6:0] G_P     = 7'b0001100;
   localparam logic [6:0] G_R     = 7'b0101111;
   localparam logic [6:0] G_S     = 7'b0010010;
   localparam logic [6:0] G_U     = 7'b1000001;
   localparam logic [6:0] G_Y     = 7'b0010001;

   // Terminal counts for the DONE hold and the ERROR half-period
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ALG     = 3'd1,
      S_BUSY    = 3'd2,
      S_DONE    = 3'd3,
      S_ERR_ON  = 3'd4,
      S_ERR_OFF = 3'd5
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [1:0]       alg;
   logic [1:0]       alg_nx;
   logic             alg_valid;
   logic             alg_valid_nx;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nx;
   logic             in_error;
   logic             status_take;
   logic [27:0]      msg_nx;
   logic [13:0]      alg_field_nx;

   // Error is sticky: BUSY and DONE requests are dropped while it is shown,
   // so they neither change state nor pre-empt ACK or the blink timer.
   assign in_error    = (state == S_ERR_ON) || (state == S_ERR_OFF);
   assign status_take = STATUS_LOAD &&
                        !(in_error && ((STATUS == 2'd1) || (STATUS == 2'd2)));

   // Next-state resolution: timers/ACK first, then status overrides, then
   // the algorithm latch which coexists with every other strobe.
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      alg_nx       = alg;
      alg_valid_nx = alg_valid;

      case (state)
         S_IDLE, S_ALG, S_BUSY: begin
            count_nx = '0;
         end
         S_DONE: begin
            if (count == HOLD_LAST) begin
               state_nx = S_ALG;
               count_nx = '0;
            end else begin
               count_nx = count + CNT_ONE;
            end
         end
         S_ERR_ON, S_ERR_OFF: begin
            if (ACK) begin
               state_nx = S_ALG;
               count_nx = '0;
            end else if (count == BLINK_LAST) begin
               state_nx = (state == S_ERR_ON) ? S_ERR_OFF : S_ERR_ON;
               count_nx = '0;
            end else begin
               count_nx = count + CNT_ONE;
            end
         end
         default: begin
            state_nx = S_ALG;
            count_nx = '0;
         end
      endcase

      if (status_take) begin
         count_nx = '0;
         case (STATUS)
            2'd0:    state_nx = S_ALG;
            2'd1:    state_nx = S_BUSY;
            2'd2:    state_nx = S_DONE;
            default: state_nx = S_ERR_ON;
         endcase
      end

      if (ALG_LOAD) begin
         alg_nx       = ALGORITHM;
         alg_valid_nx = 1'b1;
         if ((state == S_IDLE) && !status_take) begin
            state_nx = S_ALG;
         end
      end
   end

   // Segment image for the state being entered, so outputs land with MODE
   always_comb begin
      alg_field_nx = {G_BLANK, G_BLANK};
      if (alg_valid_nx && (state_nx != S_IDLE) && (state_nx != S_ERR_OFF)) begin
         case (alg_nx)
            2'd0:    alg_field_nx = {G_N, G_N};
            2'd1:    alg_field_nx = {G_P, G_R};
            2'd2:    alg_field_nx = {G_D, G_C};
            default: alg_field_nx = {G_B, G_A};
         endcase
      end

      case (state_nx)
         S_BUSY:   msg_nx = {G_B, G_U, G_S, G_Y};
         S_DONE:   msg_nx = {G_D, G_O, G_N, G_E};
         S_ERR_ON: msg_nx = {G_E, G_R, G_R, G_BLANK};
         default:  msg_nx = {G_BLANK, G_BLANK, G_BLANK, G_BLANK};
      endcase
   end

   // State, algorithm latch, timer and registered display outputs
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         alg       <= 2'd0;
         alg_valid <= 1'b0;
         count     <= '0;
         HEX5      <= G_BLANK;
         HEX4      <= G_BLANK;
         HEX3      <= G_BLANK;
         HEX2      <= G_BLANK;
         HEX1      <= G_BLANK;
         HEX0      <= G_BLANK;
         MODE      <= 3'd0;
      end else begin
         state                    <= state_nx;
         alg                      <= alg_nx;
         alg_valid                <= alg_valid_nx;
         count                    <= count_nx;
         {HEX5, HEX4, HEX3, HEX2} <= msg_nx;
         {HEX1, HEX0}             <= alg_field_nx;
         MODE                     <= state_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_msg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_msg_scheduler
// Purpose  : Self-checking bench for hex_msg_scheduler: directed scenarios
//            with literal expectations, then randomized strobes against a
//            message/timer model of the display bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_msg_scheduler;

   localparam int HOLD  = 8;
   localparam int BLINK = 4;

   localparam int M_IDLE = 0, M_ALG = 1, M_BUSY = 2, M_DONE = 3, M_EON = 4, M_EOFF = 5;

   localparam logic [6:0] K_BL = 7'b1111111;
   localparam logic [6:0] K_A  = 7'b0001000;
   localparam logic [6:0] K_B  = 7'b0000011;
   localparam logic [6:0] K_C  = 7'b1000110;
   localparam logic [6:0] K_D  = 7'b0100001;
   localparam logic [6:0] K_E  = 7'b0000110;
   localparam logic [6:0] K_N  = 7'b0101011;
   localparam logic [6:0] K_O  = 7'b0100011;
   localparam logic [6:0] K_P  = 7'b0001100;
   localparam logic [6:0] K_R  = 7'b0101111;
   localparam logic [6:0] K_S  = 7'b0010010;
   localparam logic [6:0] K_U  = 7'b1000001;
   localparam logic [6:0] K_Y  = 7'b0010001;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N  = 1'b1;
   logic [1:0] ALGORITHM = 2'd0;
   logic       ALG_LOAD = 1'b0;
   logic [1:0] STATUS = 2'd0;
   logic       STATUS_LOAD = 1'b0;
   logic       ACK = 1'b0;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [2:0] MODE;
   logic [41:0] hex_all;

   int n_cmp  = 0;
   int n_fail = 0;
   bit armed  = 1'b0;

   // Model of the bank: mode, latched algorithm and cycles left in a timed view
   int m_mode  = M_IDLE;
   int m_alg   = 0;
   bit m_valid = 1'b0;
   int m_left  = 0;

   assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   hex_msg_scheduler #(
      .HOLD_CYCLES (HOLD),
      .BLINK_CYCLES(BLINK),
      .CNT_W       (4)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .ALGORITHM  (ALGORITHM),
      .ALG_LOAD   (ALG_LOAD),
      .STATUS     (STATUS),
      .STATUS_LOAD(STATUS_LOAD),
      .ACK        (ACK),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5),
      .MODE       (MODE)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [6:0] glyph(input byte c);
      case (c)
         "A": glyph = K_A;   "b": glyph = K_B;   "C": glyph = K_C;
         "d": glyph = K_D;   "E": glyph = K_E;   "n": glyph = K_N;
         "o": glyph = K_O;   "P": glyph = K_P;   "r": glyph = K_R;
         "S": glyph = K_S;   "U": glyph = K_U;   "y": glyph = K_Y;
         default: glyph = K_BL;
      endcase
   endfunction

   // Text the bank should read left to right, converted to segments
   function automatic logic [41:0] expected_hex();
      string names[4];
      string msg, algf, txt;
      logic [41:0] r;
      names[0] = "nn"; names[1] = "Pr"; names[2] = "dC"; names[3] = "bA";
      case (m_mode)
         M_BUSY:  msg = "bUSy";
         M_DONE:  msg = "donE";
         M_EON:   msg = "Err ";
         default: msg = "    ";
      endcase
      if (m_valid && m_mode != M_IDLE && m_mode != M_EOFF) algf = names[m_alg];
      else algf = "  ";
      txt = {msg, algf};
      r = '0;
      for (int i = 0; i < 6; i++) r[(5 - i) * 7 +: 7] = glyph(txt.getc(i));
      return r;
   endfunction

   // Reference behaviour per clock edge
   always @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         m_mode = M_IDLE; m_alg = 0; m_valid = 1'b0; m_left = 0;
      end else begin
         bit err_now, st_eff;
         int prev;
         prev    = m_mode;
         err_now = (m_mode == M_EON) || (m_mode == M_EOFF);
         st_eff  = STATUS_LOAD && !(err_now && (STATUS == 2'd1 || STATUS == 2'd2));
         if (st_eff) begin
            if (STATUS == 2'd0) m_mode = M_ALG;
            else if (STATUS == 2'd1) m_mode = M_BUSY;
            else if (STATUS == 2'd2) begin m_mode = M_DONE; m_left = HOLD; end
            else begin m_mode = M_EON; m_left = BLINK; end
         end else if (err_now && ACK) begin
            m_mode = M_ALG;
         end else if (m_mode == M_DONE) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_ALG;
         end else if (err_now) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_mode = (m_mode == M_EON) ? M_EOFF : M_EON;
               m_left = BLINK;
            end
         end
         if (ALG_LOAD) begin
            m_alg = int'(ALGORITHM);
            m_valid = 1'b1;
            if (prev == M_IDLE && !st_eff) m_mode = M_ALG;
         end
      end
   end

   // Continuous comparison against the model, away from the active edge
   always @(negedge CLOCK_50) begin
      if (armed) begin
         logic [41:0] eh;
         eh = expected_hex();
         n_cmp++;
         if (MODE !== 3'(m_mode)) begin
            n_fail++;
            $display("FAIL model_mode t=%0t: MODE=%0d expected=%0d", $time, MODE, m_mode);
         end
         n_cmp++;
         if (hex_all !== eh) begin
            n_fail++;
            $display("FAIL model_hex t=%0t: HEX5..0=%h expected=%h", $time, hex_all, eh);
         end
      end
   end

   task automatic chk(input string name, input logic [41:0] got, input logic [41:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic drive(input logic al, input logic [1:0] a, input logic sl,
                        input logic [1:0] s, input logic k);
      ALG_LOAD = al; ALGORITHM = a; STATUS_LOAD = sl; STATUS = s; ACK = k;
      step();
      ALG_LOAD = 1'b0; STATUS_LOAD = 1'b0; ACK = 1'b0;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      step(); step();
      RESET_N = 1'b1;
      step();
   endtask

   localparam logic [41:0] ALL_BLANK = {6{K_BL}};

   initial begin
      int cnt;
      #2 RESET_N = 1'b0;
      armed = 1'b1;
      step(); step();
      RESET_N = 1'b1;
      step();
      chk("reset_mode", 42'(MODE), 42'd0);
      chk("reset_hex", hex_all, ALL_BLANK);

      // Algorithm load from IDLE and reload
      drive(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
      chk("alg_mode", 42'(MODE), 42'd1);
      chk("alg_dC", hex_all, {K_BL, K_BL, K_BL, K_BL, K_D, K_C});
      drive(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      chk("alg_bA", hex_all, {K_BL, K_BL, K_BL, K_BL, K_B, K_A});

      // BUSY from IDLE leaves the algorithm field blank until a load
      do_reset();
      drive(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
      chk("idle_busy_mode", 42'(MODE), 42'd2);
      chk("idle_busy_hex", hex_all, {K_B, K_U, K_S, K_Y, K_BL, K_BL});
      drive(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
      chk("busy_alg_fill", hex_all, {K_B, K_U, K_S, K_Y, K_P, K_R});

      // DONE visible for exactly HOLD cycles
      drive(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
      chk("done_hex", hex_all, {K_D, K_O, K_N, K_E, K_P, K_R});
      cnt = 0;
      while (MODE == 3'd3 && cnt < 40) begin cnt++; step(); end
      chk("done_len", 42'(cnt), 42'(HOLD));
      chk("done_after", 42'(MODE), 42'd1);

      // Restart DONE during its fifth cycle
      drive(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
      repeat (4) step();
      drive(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
      cnt = 0;
      while (MODE == 3'd3 && cnt < 40) begin cnt++; step(); end
      chk("done_restart_len", 42'(cnt), 42'(HOLD));

      // Asynchronous reset mid-DONE
      drive(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
      step();
      #2 RESET_N = 1'b0;
      #1;
      chk("async_rst_mode", 42'(MODE), 42'd0);
      chk("async_rst_hex", hex_all, ALL_BLANK);
      step();
      RESET_N = 1'b1;
      repeat (3) step();
      chk("post_rst_hold", {39'd0, MODE} ^ hex_all, ALL_BLANK);

      // Error blink, ignored BUSY, ACK
      drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
      drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
      chk("err_on_mode", 42'(MODE), 42'd4);
      chk("err_on_hex", hex_all, {K_E, K_R, K_R, K_BL, K_N, K_N});
      for (int i = 0; i < 3; i++) begin step(); chk("err_on_hold", 42'(MODE), 42'd4); end
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
         else step();
         chk("err_off_mode", 42'(MODE), 42'd5);
         chk("err_off_hex", hex_all, ALL_BLANK);
      end
      step();
      chk("err_back_on", 42'(MODE), 42'd4);
      drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      chk("ack_mode", 42'(MODE), 42'd1);

      // ACK + code 3 on the last ERR_ON cycle restarts ERR_ON
      drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
      repeat (3) step();
      drive(1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
      chk("restart_mode", 42'(MODE), 42'd4);
      for (int i = 0; i < 3; i++) begin step(); chk("restart_hold", 42'(MODE), 42'd4); end
      step();
      chk("restart_off", 42'(MODE), 42'd5);
      drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);

      // ALG_LOAD with BUSY in the same cycle
      drive(1'b1, 2'd1, 1'b1, 2'd1, 1'b0);
      chk("same_cycle_mode", 42'(MODE), 42'd2);
      chk("same_cycle_hex", hex_all, {K_B, K_U, K_S, K_Y, K_P, K_R});

      // Randomized strobes, checked continuously against the model
      for (int i = 0; i < 3000; i++) begin
         RESET_N     = ($urandom_range(0, 149) != 0);
         ALGORITHM   = 2'($urandom_range(0, 3));
         ALG_LOAD    = ($urandom_range(0, 5) == 0);
         STATUS      = 2'($urandom_range(0, 3));
         STATUS_LOAD = ($urandom_range(0, 6) == 0);
         ACK         = ($urandom_range(0, 7) == 0);
         step();
      end
      RESET_N = 1'b1; ALG_LOAD = 1'b0; STATUS_LOAD = 1'b0; ACK = 1'b0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hex_msg_scheduler.md
Name: hex_msg_scheduler

Overview:
- Owns the six-digit HEX bank of the scaler coprocessor board.
- Schedules what the bank shows:
  - the two-letter code of the selected scaling algorithm;
  - timed or blinking status messages (BUSY, DONE, ERROR) raised by the coprocessor control path.
- Registers all segment outputs and resolves contention between algorithm updates and status events.

Parameters:
- HOLD_CYCLES, 50000000, cycles DONE stays on the bank before reverting to the algorithm view; must be ≥2.
- BLINK_CYCLES, 12500000, half-period of the ERROR blink in cycles; must be ≥2.
- CNT_W, 26, counter width; must hold max(HOLD_CYCLES, BLINK_CYCLES)-1.

Ports:
- CLOCK_50  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ALGORITHM  in  2  algorithm select: 0 NN, 1 PR, 2 DC, 3 BA.
- ALG_LOAD  in  1  one-cycle strobe; latch ALGORITHM.
- STATUS  in  2  status code: 0 clear, 1 busy, 2 done, 3 error.
- STATUS_LOAD  in  1  one-cycle strobe; act on STATUS.
- ACK  in  1  one-cycle strobe; clears an error display.
- HEX0..HEX5  out  7 each  active-low segments, bit0=a … bit6=g. HEX5 is the leftmost digit.
- MODE  out  3  current state: 0 IDLE, 1 ALG, 2 BUSY, 3 DONE, 4 ERR_ON, 5 ERR_OFF.

Behaviour:
- Reset (async assert, sync release):
  - all HEX = 1111111, MODE = 0.
  - alg register = 0, alg_valid = 0, counter = 0.
  - Reset mid-message discards the message immediately.
- Glyphs (active-low gfedcba):
  - blank 1111111, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, n 0101011, o 0100011, P 0001100, r 0101111, S 0010010, U 1000001, y 0010001.
- Algorithm field HEX1,HEX0:
  - NN "nn", PR "Pr", DC "dC", BA "bA".
  - Shows blank while alg_valid = 0.
  - Shown in every state except IDLE and ERR_OFF.
- Message field HEX5..HEX2:
  - ALG: blank.
  - BUSY: "bUSy".
  - DONE: "donE".
  - ERR_ON: "Err" plus a blank digit.
  - ERR_OFF: all six digits blank.
- Latency: outputs and MODE are registered and reflect a strobe on the cycle after the strobe edge.
- ALG_LOAD:
  - Latches ALGORITHM and sets alg_valid in any state.
  - In IDLE, moves to ALG.
  - Does not change the state otherwise.
- STATUS_LOAD, any state:
  - 0 → ALG.
  - 1 → BUSY; held indefinitely.
  - 2 → DONE; counter cleared.
  - 3 → ERR_ON; counter cleared.
  - Exception: while in ERR_ON/ERR_OFF, codes 1 and 2 are ignored. Error is sticky.
  - Code 3 while already in error restarts at ERR_ON.
- DONE timing:
  - Counter increments each cycle.
  - When counter = HOLD_CYCLES-1, go to ALG and clear the counter.
  - DONE is visible for exactly HOLD_CYCLES cycles.
  - A new DONE load restarts the count.
- ERROR blink:
  - Counter increments each cycle.
  - At BLINK_CYCLES-1, toggle ERR_ON↔ERR_OFF and clear the counter.
- ACK:
  - In ERR_ON/ERR_OFF, go to ALG.
  - Ignored in other states.
- Simultaneous events:
  - STATUS_LOAD has priority over ACK and over the counter expiry.
  - ALG_LOAD combined with any other strobe: both take effect in the same cycle, and the new algorithm code is displayed.
- IDLE + STATUS_LOAD: enters the status state; the algorithm field stays blank until the first ALG_LOAD.
- Unused MODE encodings 6 and 7 recover to ALG on the next clock.

Test Plan:
(HOLD_CYCLES=8, BLINK_CYCLES=4)
- Reset check: RESET_N low mid-DONE → within the same cycle all HEX = 1111111 and MODE = 0. After release, with no strobes, the outputs hold.
- Algorithm load: ALG_LOAD with ALGORITHM=2 → next cycle MODE=1, HEX1=0100001, HEX0=1000110, HEX5..2 blank. Reload with 3 → HEX1=0000011, HEX0=0001000.
- DONE hold and restart:
  - STATUS_LOAD=2 → MODE=3, HEX5..2 = "donE" for exactly 8 cycles, then MODE=1.
  - A second DONE load at cycle 5 extends the display to 8 cycles after that load.
- Error blink and ACK:
  - STATUS_LOAD=3 → MODE alternates 4,5 every 4 cycles.
  - In MODE=5 all HEX are blank.
  - STATUS_LOAD=1 is ignored while in error.
  - ACK → MODE=1.
- Same-cycle strobes: ACK together with STATUS_LOAD=3 while in error → restarts at ERR_ON. ALG_LOAD=1 together with STATUS_LOAD=1 → MODE=2, HEX5..0 = "bUSyPr".
- IDLE status: STATUS_LOAD=1 before any ALG_LOAD → "bUSy" shown with HEX1, HEX0 blank. A later ALG_LOAD fills HEX1, HEX0.
